// File: rtl/nios2_mul_pkg.sv
// nios2_mul_pkg: shared op codes, FSM states and the
// partial-product shift table for the multiply sequencer.
package nios2_mul_pkg;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULXUU = 2'd1;
  localparam logic [1:0] OP_MULXSU = 2'd2;
  localparam logic [1:0] OP_MULXSS = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIX,
    RESP
  } state_t;

  // k=0 lo*lo, k=1 hi*lo, k=2 lo*hi, k=3 hi*hi
  function automatic logic [5:0] pp_shift(
    input logic [1:0] k
  );
    logic [5:0] s;
    unique case (k)
      2'd0:    s = 6'd0;
      2'd1:    s = 6'd16;
      2'd2:    s = 6'd16;
      default: s = 6'd32;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/nios2_mul_pp16.sv
// nios2_mul_pp16: 16x16 unsigned multiplier, registered output.
// Ports: clk, reset_n (sync), ena, a, b in; p (32-bit) out.
module nios2_mul_pp16 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ena,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p <= '0;
    end else if (ena) begin
      p <= 32'(a) * 32'(b);
    end
  end

endmodule

// File: rtl/nios2_mul_seq.sv
// nios2_mul_seq: multi-cycle 32x32 multiply sequencer (mul/mulx*).
// Ports: req_* handshake in, resp_* handshake out, flush, busy.
module nios2_mul_seq
  import nios2_mul_pkg::*;
#(
  parameter int          ISSUE_LAT    = 1,
  parameter logic [31:0] RESET_RESULT = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic        busy
);

  // The FSM timing below assumes a single register stage in the cell.
  if (ISSUE_LAT != 1) begin : g_lat_chk
    $error("nios2_mul_seq: ISSUE_LAT must be 1");
  end

  state_t      state;
  logic [1:0]  idx;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [63:0] acc;
  logic        pv;
  logic [1:0]  pk;

  logic [15:0] cell_a;
  logic [15:0] cell_b;
  logic [31:0] cell_p;
  logic        cell_ena;
  logic [63:0] addend;
  logic [31:0] fix_hi;

  assign req_ready = (state == IDLE) && !flush;
  assign busy      = (state != IDLE);
  assign cell_ena  = (state == ISSUE);

  always_comb begin
    cell_a = idx[0] ? a_q[31:16] : a_q[15:0];
    cell_b = idx[1] ? b_q[31:16] : b_q[15:0];
  end

  nios2_mul_pp16 u_pp16 (
    .clk     (clk),
    .reset_n (reset_n),
    .ena     (cell_ena),
    .a       (cell_a),
    .b       (cell_b),
    .p       (cell_p)
  );

  assign addend = {32'b0, cell_p} << pp_shift(pk);

  // Unsigned high word turned into a signed one.
  always_comb begin
    fix_hi = acc[63:32];
    if (a_q[31] && (op_q == OP_MULXSU || op_q == OP_MULXSS))
      fix_hi = fix_hi - b_q;
    if (b_q[31] && (op_q == OP_MULXSS))
      fix_hi = fix_hi - a_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc         <= '0;
      pv          <= 1'b0;
      pk          <= '0;
      resp_valid  <= 1'b0;
      resp_result <= RESET_RESULT;
    end else begin
      // pv tracks which cell output is a fresh product
      pv <= (state == ISSUE) && !flush;
      pk <= idx;
      if (pv)
        acc <= acc + addend;

      if (flush && state != IDLE) begin
        state      <= IDLE;
        idx        <= '0;
        pv         <= 1'b0;
        resp_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid && req_ready) begin
              op_q  <= req_op;
              a_q   <= req_src1;
              b_q   <= req_src2;
              acc   <= '0;
              idx   <= '0;
              state <= ISSUE;
            end
          end
          ISSUE: begin
            idx <= idx + 2'd1;
            if (idx == 2'd3)
              state <= DRAIN;
          end
          DRAIN: begin
            state <= FIX;
          end
          FIX: begin
            resp_result <= (op_q == OP_MUL) ? acc[31:0] : fix_hi;
            resp_valid  <= 1'b1;
            state       <= RESP;
          end
          RESP: begin
            if (resp_ready) begin
              resp_valid <= 1'b0;
              state      <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
